// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: one shared frame counter, double-buffered per-channel
// pulse widths that are only applied at frame boundaries, with optional per-frame slew limiting.
module servo_pwm_multi #(
  parameter int N_CH        = 4,
  parameter int FRAME_CYC   = 1000000,
  parameter int MIN_CYC     = 27200,
  parameter int CYC_PER_DEG = 515,
  parameter int MAX_ANGLE   = 180,
  parameter int RESET_ANGLE = 90,
  parameter int SLEW_CYC    = 0,
  localparam int CNT_W      = $clog2(FRAME_CYC),
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [7:0]        wr_angle,
  output logic [N_CH-1:0]   servo,
  output logic              frame_start,
  output logic [N_CH-1:0]   busy
);

  localparam int MAX_W_INT = MIN_CYC + MAX_ANGLE * CYC_PER_DEG;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYC - 1);
  localparam logic [CNT_W-1:0] RESET_W  = CNT_W'(MIN_CYC + RESET_ANGLE * CYC_PER_DEG);
  // A slew step at least as large as any legal width behaves exactly like an unlimited jump.
  localparam bit SLEW_LIMITED = (SLEW_CYC > 0) && (SLEW_CYC < FRAME_CYC);
  localparam logic [CNT_W-1:0] SLEW_STEP = SLEW_LIMITED ? CNT_W'(SLEW_CYC) : '0;

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("servo_pwm_multi: N_CH must be in 1..16");
  end
  if (MAX_W_INT >= FRAME_CYC) begin : g_bad_width
    $error("servo_pwm_multi: widest pulse does not fit inside the frame");
  end
  if (RESET_ANGLE > MAX_ANGLE || MAX_ANGLE > 255) begin : g_bad_angle
    $error("servo_pwm_multi: RESET_ANGLE must not exceed MAX_ANGLE, MAX_ANGLE must fit 8 bits");
  end

  function automatic logic [CNT_W-1:0] angle_to_width(input logic [7:0] angle);
    int a;
    int w;
    a = (int'(angle) > MAX_ANGLE) ? MAX_ANGLE : int'(angle);
    w = MIN_CYC + a * CYC_PER_DEG;
    return CNT_W'(w);
  endfunction

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             started_reg;
  logic             frame_start_reg;
  logic             wr_ready_reg;
  logic             update;
  logic             wr_accept;
  logic             wr_ch_ok;
  logic [CNT_W-1:0] wr_width;

  // The first cycle after reset release only arms the counter, so frame 0 is a full frame.
  assign update    = started_reg && (cnt_reg == LAST_CNT);
  assign wr_accept = wr_valid && wr_ready_reg;
  assign wr_ch_ok  = (int'(wr_ch) < N_CH);
  assign wr_width  = angle_to_width(wr_angle);

  always_comb begin
    cnt_next = '0;
    if (started_reg && !update) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg         <= '0;
      started_reg     <= 1'b0;
      frame_start_reg <= 1'b0;
      wr_ready_reg    <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      started_reg     <= 1'b1;
      frame_start_reg <= (cnt_next == '0);
      wr_ready_reg    <= (cnt_next != LAST_CNT);
    end
  end

  assign frame_start = frame_start_reg;
  assign wr_ready    = wr_ready_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] target_reg;
    logic [CNT_W-1:0] target_next;
    logic [CNT_W-1:0] active_reg;
    logic [CNT_W-1:0] active_next;
    logic [CNT_W-1:0] diff;
    logic [CNT_W-1:0] step;
    logic             up;
    logic             en_q_reg;
    logic             en_q_next;
    logic             servo_reg;
    logic             busy_reg;

    always_comb begin
      target_next = target_reg;
      if (wr_accept && wr_ch_ok && (wr_ch == CH_W'(gi))) begin
        target_next = wr_width;
      end

      // Slew uses the pre-write target; writes are never accepted on the update cycle anyway.
      up   = (target_reg > active_reg);
      diff = up ? (target_reg - active_reg) : (active_reg - target_reg);
      step = diff;
      if (SLEW_LIMITED && (diff > SLEW_STEP)) begin
        step = SLEW_STEP;
      end

      active_next = active_reg;
      en_q_next   = en_q_reg;
      if (update) begin
        active_next = up ? (active_reg + step) : (active_reg - step);
        en_q_next   = en[gi];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        target_reg <= RESET_W;
        active_reg <= RESET_W;
        en_q_reg   <= 1'b0;
        servo_reg  <= 1'b0;
        busy_reg   <= 1'b0;
      end else begin
        target_reg <= target_next;
        active_reg <= active_next;
        en_q_reg   <= en_q_next;
        servo_reg  <= en_q_next && (cnt_next < active_next);
        busy_reg   <= (active_next != target_next);
      end
    end

    assign servo[gi] = servo_reg;
    assign busy[gi]  = busy_reg;
  end

endmodule
